// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with programmable step, terminal limit, wrap/saturate mode,
// terminal-count pulse and sticky overflow. Optional prescaler enabled by COUNTER_PRESCALE_EN.
module counter_updown_param #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned PRE_DIV = 4
) (
  input  logic              clk,
  input  logic              p_reset,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              tc,
  output logic              ovf
);

  localparam int unsigned SUM_W = WIDTH + 1;

  // Reject parameter sets outside the supported range at elaboration.
  if (WIDTH < 2 || WIDTH > 64 || STEP_W < 1 || STEP_W > WIDTH || PRE_DIV < 1) begin : g_bad_param
    $error("counter_updown_param: illegal parameter combination");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [SUM_W-1:0] cnt_ext;
  logic [SUM_W-1:0] step_ext;
  logic [SUM_W-1:0] lim_ext;
  logic [SUM_W-1:0] sum_up;
  logic             step_nz_c;
  logic             up_fit_c;
  logic             dn_fit_c;
  logic             tick_c;
  logic             advance_c;
  logic             boundary_c;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PSC_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [PSC_W-1:0] psc_q, psc_d;

  assign tick_c = (psc_q == PSC_W'(PRE_DIV - 1));

  // Prescaler counts enabled cycles; clr/load restart it.
  always_comb begin
    psc_d = psc_q;
    if (clr || load) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = tick_c ? '0 : psc_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge p_reset) begin
    if (!p_reset) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  assign tick_c = 1'b1;
`endif

  // One extra bit keeps cnt+step from wrapping before the limit compare.
  assign cnt_ext   = {1'b0, cnt_q};
  assign step_ext  = SUM_W'(step);
  assign lim_ext   = {1'b0, limit};
  assign sum_up    = cnt_ext + step_ext;
  assign step_nz_c = |step;
  assign up_fit_c  = (sum_up <= lim_ext);
  assign dn_fit_c  = (cnt_ext >= step_ext);

  assign advance_c  = en & ~clr & ~load & tick_c;
  assign boundary_c = advance_c & step_nz_c & (dir ? ~up_fit_c : ~dn_fit_c);

  // Next count, terminal pulse and sticky flag; a boundary set beats ovf_clr.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~ovf_clr;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (advance_c && step_nz_c) begin
      if (dir) begin
        if (up_fit_c) begin
          cnt_d = sum_up[WIDTH-1:0];
        end else begin
          cnt_d = sat_mode ? limit : '0;
        end
      end else begin
        if (dn_fit_c) begin
          cnt_d = cnt_q - step_ext[WIDTH-1:0];
        end else begin
          cnt_d = sat_mode ? '0 : limit;
        end
      end
    end
    if (boundary_c) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge p_reset) begin
    if (!p_reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_out = cnt_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_counter_updown_param.sv
// Scoreboard bench for counter_updown_param: stimulus pushes model expectations, a monitor
// pops and compares one entry per clock. Honours COUNTER_PRESCALE_EN for the model divide ratio.
module tb_counter_updown_param;

  localparam int unsigned W       = 32;
  localparam int unsigned SW      = 8;
  localparam int unsigned DUT_DIV = 4;
`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PDIV = DUT_DIV;
`else
  localparam int unsigned PDIV = 1;
`endif

  logic          clk = 1'b0;
  logic          p_reset;
  logic          en, clr, load, dir, sat_mode, ovf_clr;
  logic [W-1:0]  load_val, limit;
  logic [SW-1:0] step;
  logic [W-1:0]  cnt_out;
  logic          tc, ovf;

  int checks   = 0;
  int failures = 0;
  int next_id  = 0;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
    logic         ovf;
    int           id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference state: counter value, sticky flag and enabled-cycle count modulo PDIV.
  longint unsigned m_cnt;
  logic            m_ovf;
  int unsigned     m_psc;

  counter_updown_param #(
    .WIDTH  (W),
    .STEP_W (SW),
    .PRE_DIV(DUT_DIV)
  ) dut (
    .clk     (clk),
    .p_reset (p_reset),
    .en      (en),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .dir     (dir),
    .step    (step),
    .limit   (limit),
    .sat_mode(sat_mode),
    .ovf_clr (ovf_clr),
    .cnt_out (cnt_out),
    .tc      (tc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s id=%0d: got %0h required %0h", nm, id, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (p_reset && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("cnt", mon_e.id, 64'(cnt_out), 64'(mon_e.cnt));
      check("tc",  mon_e.id, 64'(tc),      64'(mon_e.tc));
      check("ovf", mon_e.id, 64'(ovf),     64'(mon_e.ovf));
    end
  end

  task automatic idle_inputs();
    en = 1'b0; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    dir = 1'b1; sat_mode = 1'b0; step = '0; limit = '0; load_val = '0;
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_psc = 0;
  endtask

  // Apply one cycle of inputs and queue the response the counter rules predict.
  task automatic drive(input logic e_, input logic c_, input logic l_, input logic [W-1:0] lv,
                       input logic d_, input logic [SW-1:0] s_, input logic [W-1:0] lim,
                       input logic sat, input logic oc);
    longint unsigned n_cnt;
    int unsigned     n_psc;
    bit              tick;
    bit              ev;
    exp_t            x;
    @(negedge clk);
    en = e_; clr = c_; load = l_; load_val = lv; dir = d_;
    step = s_; limit = lim; sat_mode = sat; ovf_clr = oc;
    n_cnt = m_cnt; n_psc = m_psc; tick = 1'b0; ev = 1'b0;
    if (c_) begin
      n_cnt = 0; n_psc = 0;
    end else if (l_) begin
      n_cnt = longint'(lv); n_psc = 0;
    end else if (e_) begin
      if (m_psc == PDIV - 1) begin
        tick = 1'b1; n_psc = 0;
      end else begin
        n_psc = m_psc + 1;
      end
    end
    if (tick && s_ != 0) begin
      if (d_) begin
        if (m_cnt + longint'(s_) <= longint'(lim)) n_cnt = m_cnt + longint'(s_);
        else begin ev = 1'b1; n_cnt = sat ? longint'(lim) : 0; end
      end else begin
        if (m_cnt >= longint'(s_)) n_cnt = m_cnt - longint'(s_);
        else begin ev = 1'b1; n_cnt = sat ? 0 : longint'(lim); end
      end
    end
    m_ovf = ev | (m_ovf & ~oc);
    m_cnt = n_cnt;
    m_psc = n_psc;
    x.cnt = W'(n_cnt);
    x.tc  = ev;
    x.ovf = m_ovf;
    x.id  = next_id++;
    sb_q.push_back(x);
  endtask

  initial begin
    logic [W-1:0]  r_lim, r_lv;
    logic [SW-1:0] r_step;
    int            r, guard;

    idle_inputs();
    model_reset();
    p_reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cnt", -1, 64'(cnt_out), 64'd0);
    check("rst_tc",  -1, 64'(tc),      64'd0);
    check("rst_ovf", -1, 64'(ovf),     64'd0);
    @(negedge clk);
    p_reset = 1'b1;

    // Down wrap from 0 lands on 0x25 with tc and ovf raised, then async reset mid-cycle.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 8'd1, 32'h25, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd1, 32'h25, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    p_reset = 1'b0;
    #1;
    check("arst_cnt", -2, 64'(cnt_out), 64'd0);
    check("arst_tc",  -2, 64'(tc),      64'd0);
    check("arst_ovf", -2, 64'(ovf),     64'd0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    p_reset = 1'b1;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Up wrap at limit 9, step 3.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 8'd3, 32'd9, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd3, 32'd9, 1'b0, 1'b0);

    // Down saturate from 5, then ovf_clr on a pinned cycle and on an idle cycle.
    drive(1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 8'd2, 32'd9, 1'b1, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd2, 32'd9, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd2, 32'd9, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd2, 32'd9, 1'b1, 1'b1);

    // Priority and out-of-range load.
    drive(1'b1, 1'b1, 1'b1, 32'h1234, 1'b1, 8'd1, 32'd10, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 8'd1, 32'd10, 1'b0, 1'b0);
    repeat (PDIV) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd1, 32'd10, 1'b0, 1'b0);

    // Full-range boundaries: no truncation at the top of the counter.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 8'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (PDIV) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 8'd1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    repeat (PDIV) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // step=0 above the limit is not a boundary.
    drive(1'b0, 1'b0, 1'b1, 32'd50, 1'b1, 8'd0, 32'd10, 1'b0, 1'b1);
    repeat (PDIV + 1) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd0, 32'd10, 1'b0, 1'b0);

    // Continuous enable then a two-cycle gap.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 8'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (12) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (2)  drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 8'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Randomised traffic.
    r_lim = 32'd20;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      r_lim = 32'($urandom_range(0, 40));
        else if (r <= 7) r_lim = 32'hFFFF_FFFF;
        else if (r == 8) r_lim = 32'($urandom);
        else             r_lim = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end
      if (r_lim < 32'h1000) r_lv = 32'($urandom_range(0, int'(r_lim) + 5));
      else                  r_lv = r_lim - 32'($urandom_range(0, 20));
      if ($urandom_range(0, 4) != 0) r_step = SW'($urandom_range(0, 6));
      else                           r_step = SW'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 19) == 0), r_lv, 1'($urandom_range(0, 1)), r_step,
            r_lim, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("drain", -3, 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
